// File: rtl/point_ctrl_pkg.sv
// Shared types and widths for the pointwise-convolution address sequencer.
package point_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    WWAIT,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int WADDR_W   = 10;
  localparam int RADDR_W   = 13;
  localparam int OADDR_W   = 14;
  localparam int WRITE_LAT = 3;

  localparam int CH_W  = 4;
  localparam int FLT_W = 6;
  localparam int PIX_W = 14;

endpackage

// File: rtl/point_write_pipe.sv
// Fixed-latency delay line carrying {valid, address} from a feature read to its
// output write: memory read, MAC and activation stages.
module point_write_pipe
  import point_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [OADDR_W-1:0] in_addr,
  output logic               out_valid,
  output logic [OADDR_W-1:0] out_addr
);

  logic [WRITE_LAT-1:0] valid_q, valid_d;
  logic [OADDR_W-1:0]   addr_q [WRITE_LAT];
  logic [OADDR_W-1:0]   addr_d [WRITE_LAT];

  always_comb begin
    valid_d   = {valid_q[WRITE_LAT-2:0], in_valid};
    addr_d[0] = in_addr;
    for (int i = 1; i < WRITE_LAT; i++) begin
      addr_d[i] = addr_q[i-1];
    end
  end

  // Reset flushes in-flight writes so an aborted run leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < WRITE_LAT; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < WRITE_LAT; i++) begin
        addr_q[i] <= addr_d[i];
      end
    end
  end

  assign out_valid = valid_q[WRITE_LAT-1];
  assign out_addr  = addr_q[WRITE_LAT-1];

endmodule

// File: rtl/point_controller.sv
// Address/enable sequencer for the 1x1 convolution engine: walks filters,
// channel groups and pixels, driving weight/feature reads and output writes.
module point_controller
  import point_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               Point_Enabel,
  input  logic [WADDR_W-1:0] W_start_address,
  input  logic [CH_W-1:0]    filter_channel_max,
  input  logic [FLT_W-1:0]   filter_number_max,
  input  logic [PIX_W-1:0]   window_size_max,
  input  logic               activation_function_enable,
  output logic [WADDR_W-1:0] weights_address,
  output logic               weights_read_en,
  output logic [RADDR_W-1:0] read_data_address,
  output logic               data_read_en,
  output logic [OADDR_W-1:0] write_data_address,
  output logic               data_write_en,
  output logic               Point_End
);

  state_t state_q, state_d;

  logic [FLT_W-1:0]   f_q, f_d, fmax_q, fmax_d;
  logic [CH_W-1:0]    c_q, c_d, cmax_q, cmax_d;
  logic [PIX_W-1:0]   p_q, p_d, wmax_q, wmax_d;
  logic [WADDR_W-1:0] wbase_q, wbase_d;
  logic [RADDR_W-1:0] rbase_q, rbase_d;
  logic [OADDR_W-1:0] obase_q, obase_d;
  logic               wren_q, wren_d;
  logic               rden_q, rden_d;
  logic               end_q, end_d;

  logic               pipe_in_valid;
  logic [OADDR_W-1:0] pipe_in_addr;
  logic               pipe_out_valid;
  logic [OADDR_W-1:0] pipe_out_addr;

  // The activation select only steers the datapath; sequencing ignores it.
  logic unused_act;
  assign unused_act = activation_function_enable;

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    c_d     = c_q;
    p_d     = p_q;
    fmax_d  = fmax_q;
    cmax_d  = cmax_q;
    wmax_d  = wmax_q;
    wbase_d = wbase_q;
    rbase_d = rbase_q;
    obase_d = obase_q;

    case (state_q)
      IDLE: begin
        if (Point_Enabel) begin
          cmax_d  = (filter_channel_max == '0) ? CH_W'(1)  : filter_channel_max;
          fmax_d  = (filter_number_max == '0)  ? FLT_W'(1) : filter_number_max;
          wmax_d  = (window_size_max == '0)    ? PIX_W'(1) : window_size_max;
          wbase_d = W_start_address;
          rbase_d = '0;
          obase_d = '0;
          f_d     = '0;
          c_d     = '0;
          p_d     = '0;
          state_d = WLOAD;
        end
      end
      WLOAD: state_d = WWAIT;
      WWAIT: state_d = RUN;
      RUN: begin
        p_d = p_q + PIX_W'(1);
        if (p_q == wmax_q - PIX_W'(1)) begin
          p_d = '0;
          if (c_q != cmax_q - CH_W'(1)) begin
            c_d     = c_q + CH_W'(1);
            rbase_d = rbase_q + wmax_q[RADDR_W-1:0];
            state_d = WLOAD;
          end else if (f_q != fmax_q - FLT_W'(1)) begin
            c_d     = '0;
            rbase_d = '0;
            f_d     = f_q + FLT_W'(1);
            wbase_d = wbase_q + WADDR_W'(cmax_q);
            obase_d = obase_q + wmax_q;
            state_d = WLOAD;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      // The idle pixel counter times the drain so the last writes can retire.
      DRAIN: begin
        if (p_q == PIX_W'(WRITE_LAT - 1)) begin
          p_d     = '0;
          state_d = DONE;
        end else begin
          p_d = p_q + PIX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wren_d = (state_d == WLOAD);
    rden_d = (state_d == RUN);
    end_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      f_q     <= '0;
      c_q     <= '0;
      p_q     <= '0;
      fmax_q  <= '0;
      cmax_q  <= '0;
      wmax_q  <= '0;
      wbase_q <= '0;
      rbase_q <= '0;
      obase_q <= '0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      c_q     <= c_d;
      p_q     <= p_d;
      fmax_q  <= fmax_d;
      cmax_q  <= cmax_d;
      wmax_q  <= wmax_d;
      wbase_q <= wbase_d;
      rbase_q <= rbase_d;
      obase_q <= obase_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
      end_q   <= end_d;
    end
  end

  // Only the last channel group of a filter completes an output pixel.
  assign pipe_in_valid = rden_q && (c_q == cmax_q - CH_W'(1));
  assign pipe_in_addr  = obase_q + p_q;

  point_write_pipe u_write_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pipe_in_valid),
    .in_addr   (pipe_in_addr),
    .out_valid (pipe_out_valid),
    .out_addr  (pipe_out_addr)
  );

  assign weights_read_en    = wren_q;
  assign weights_address    = wren_q ? (wbase_q + WADDR_W'(c_q)) : '0;
  assign data_read_en       = rden_q;
  assign read_data_address  = rden_q ? (rbase_q + p_q[RADDR_W-1:0]) : '0;
  assign data_write_en      = pipe_out_valid;
  assign write_data_address = pipe_out_valid ? pipe_out_addr : '0;
  assign Point_End          = end_q;

endmodule

// File: tb/tb_point_controller.sv
// Scoreboard bench: a loop-nest reference model queues every expected strobe
// with its cycle and address; a negedge monitor pops and compares.
module tb_point_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Point_Enabel = 1'b0;
  logic [9:0]  W_start_address = '0;
  logic [3:0]  filter_channel_max = '0;
  logic [5:0]  filter_number_max = '0;
  logic [13:0] window_size_max = '0;
  logic        activation_function_enable = 1'b0;
  logic [9:0]  weights_address;
  logic        weights_read_en;
  logic [12:0] read_data_address;
  logic        data_read_en;
  logic [13:0] write_data_address;
  logic        data_write_en;
  logic        Point_End;

  typedef struct {
    int cyc;
    int addr;
  } evt_t;

  evt_t wq[$];
  evt_t rq[$];
  evt_t oq[$];
  int   endq[$];

  int cyc = 0;
  int testsRun = 0;
  int testsFailed = 0;
  bit expW, expR, expO, expE;

  point_controller dut (
    .clk                        (clk),
    .rst                        (rst),
    .Point_Enabel               (Point_Enabel),
    .W_start_address            (W_start_address),
    .filter_channel_max         (filter_channel_max),
    .filter_number_max          (filter_number_max),
    .window_size_max            (window_size_max),
    .activation_function_enable (activation_function_enable),
    .weights_address            (weights_address),
    .weights_read_en            (weights_read_en),
    .read_data_address          (read_data_address),
    .data_read_en               (data_read_en),
    .write_data_address         (write_data_address),
    .data_write_en              (data_write_en),
    .Point_End                  (Point_End)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Loop nest straight from the sequencing rules: WLOAD, WWAIT, then W reads per
  // (filter, channel group); last-group reads write 3 cycles later; done 4 after the last read.
  function automatic void modelRun(input int t0, input int ws, input int cm, input int fm, input int wm);
    int ce, fe, we, t;
    evt_t e;
    ce = (cm == 0) ? 1 : cm;
    fe = (fm == 0) ? 1 : fm;
    we = (wm == 0) ? 1 : wm;
    t  = t0;
    for (int f = 0; f < fe; f++) begin
      for (int c = 0; c < ce; c++) begin
        e.cyc  = t;
        e.addr = (ws + f * ce + c) % 1024;
        wq.push_back(e);
        for (int p = 0; p < we; p++) begin
          e.cyc  = t + 2 + p;
          e.addr = (c * we + p) % 8192;
          rq.push_back(e);
          if (c == ce - 1) begin
            e.cyc  = t + 5 + p;
            e.addr = (f * we + p) % 16384;
            oq.push_back(e);
          end
        end
        t = t + 2 + we;
      end
    end
    endq.push_back(t + 3);
  endfunction

  function automatic void pruneFrom(input int r);
    while (wq.size() > 0 && wq[$].cyc >= r) void'(wq.pop_back());
    while (rq.size() > 0 && rq[$].cyc >= r) void'(rq.pop_back());
    while (oq.size() > 0 && oq[$].cyc >= r) void'(oq.pop_back());
    while (endq.size() > 0 && endq[$] >= r) void'(endq.pop_back());
  endfunction

  always @(negedge clk) begin
    expW = (wq.size() > 0) && (wq[0].cyc == cyc);
    expR = (rq.size() > 0) && (rq[0].cyc == cyc);
    expO = (oq.size() > 0) && (oq[0].cyc == cyc);
    expE = (endq.size() > 0) && (endq[0] == cyc);
    if (weights_read_en === 1'b1 || expW) begin
      checkOutput("weights_read_en", weights_read_en, expW);
      if (expW) begin
        if (weights_read_en === 1'b1) checkOutput("weights_address", weights_address, wq[0].addr);
        void'(wq.pop_front());
      end
    end
    if (data_read_en === 1'b1 || expR) begin
      checkOutput("data_read_en", data_read_en, expR);
      if (expR) begin
        if (data_read_en === 1'b1) checkOutput("read_data_address", read_data_address, rq[0].addr);
        void'(rq.pop_front());
      end
    end
    if (data_write_en === 1'b1 || expO) begin
      checkOutput("data_write_en", data_write_en, expO);
      if (expO) begin
        if (data_write_en === 1'b1) checkOutput("write_data_address", write_data_address, oq[0].addr);
        void'(oq.pop_front());
      end
    end
    if (Point_End === 1'b1 || expE) begin
      checkOutput("Point_End", Point_End, expE);
      if (expE) void'(endq.pop_front());
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_weights_address"}, weights_address, 0);
    checkOutput({tag, "_weights_read_en"}, weights_read_en, 0);
    checkOutput({tag, "_read_data_address"}, read_data_address, 0);
    checkOutput({tag, "_data_read_en"}, data_read_en, 0);
    checkOutput({tag, "_write_data_address"}, write_data_address, 0);
    checkOutput({tag, "_data_write_en"}, data_write_en, 0);
    checkOutput({tag, "_Point_End"}, Point_End, 0);
  endtask

  // Start one run; optionally pulse start while busy or abort with reset at loop step n.
  task automatic applyStimulus(input int ws, input int cm, input int fm, input int wm,
                               input int busyPulse, input int resetAt);
    int limit;
    @(negedge clk);
    W_start_address    = 10'(ws);
    filter_channel_max = 4'(cm);
    filter_number_max  = 6'(fm);
    window_size_max    = 14'(wm);
    Point_Enabel       = 1'b1;
    modelRun(cyc + 1, ws, cm, fm, wm);
    limit = endq[$] - cyc + 20;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      Point_Enabel               = (n == busyPulse);
      activation_function_enable = 1'($urandom_range(0, 1));
      W_start_address            = 10'($urandom);
      filter_channel_max         = 4'($urandom);
      filter_number_max          = 6'($urandom);
      window_size_max            = 14'($urandom);
      if (n == resetAt) begin
        rst = 1'b1;
        pruneFrom(cyc + 1);
        @(negedge clk);
        checkAllZero("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      if (wq.size() + rq.size() + oq.size() + endq.size() == 0) break;
    end
    Point_Enabel = 1'b0;
    checkOutput("queues_drained", wq.size() + rq.size() + oq.size() + endq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    applyStimulus(0, 1, 1, 3136, 0, 0);
    applyStimulus(100, 3, 2, 4, 0, 0);
    applyStimulus(100, 3, 2, 4, 4, 0);
    applyStimulus(50, 2, 2, 10, 0, 8);
    applyStimulus(7, 0, 0, 0, 0, 0);
    applyStimulus(1020, 4, 3, 5, 2, 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(int'($urandom_range(0, 1023)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 3)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
